qosc_multi: RTL

Parametrised, time-multiplexed quadrature oscillator bank: CH independent complex phasors, each rotated by its own complex coefficient on every `step` strobe. It replaces the single-channel, fixed-width oscillator core behind the chip top level. It adds per-channel register loading over a ready/valid config port, channel enables, round-half-up with saturation, and an overrun flag. One complex multiplier is shared across all channels.

---
 rtl/qosc_pkg.sv | 39 +++
 rtl/qosc_multi_if.sv | 40 ++++
 rtl/qosc_cmul.sv | 67 ++++++
 rtl/qosc_multi.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/qosc_pkg.sv
`default_nettype none
// ============================================================================
// qosc_pkg : config-select encodings, FSM states and rounding for qosc_multi
// Rev 1.0
// ============================================================================
package qosc_pkg;

  localparam logic [1:0] SEL_CRE = 2'd0;
  localparam logic [1:0] SEL_CIM = 2'd1;
  localparam logic [1:0] SEL_ARE = 2'd2;
  localparam logic [1:0] SEL_AIM = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_A = 2'd1,
    ST_RUN_B = 2'd2
  } qosc_state_t;

  // Round half up at bit cw-2, drop cw-1 fraction bits, clamp to a w-bit range.
  // acc is the sign-extended W+CW+1 bit sum; callers keep the low w bits.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int w, input int cw);
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t  = (acc + (64'sd1 <<< (cw - 2))) >>> (cw - 1);
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (t > hi) begin
      round_sat = hi;
    end else if (t < lo) begin
      round_sat = lo;
    end else begin
      round_sat = t;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/qosc_multi_if.sv
`default_nettype none
// ============================================================================
// qosc_multi_if : config, control and output bundle of the oscillator bank
// Rev 1.0
// ============================================================================
interface qosc_multi_if #(
  parameter int W   = 16,
  parameter int CW  = 16,
  parameter int CH  = 4,
  parameter int CHW = (CH > 1) ? $clog2(CH) : 1,
  parameter int DW  = (W > CW) ? W : CW
) ();

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [CHW-1:0]        cfg_ch;
  logic [1:0]            cfg_sel;
  logic [DW-1:0]         cfg_data;
  logic [CH-1:0]         en;
  logic                  step;
  logic                  busy;
  logic                  out_valid;
  logic [CHW-1:0]        out_ch;
  logic signed [W-1:0]   out_re;
  logic signed [W-1:0]   out_im;
  logic                  overrun;
  logic                  clr_ovr;

  modport master (
    output cfg_valid, cfg_ch, cfg_sel, cfg_data, en, step, clr_ovr,
    input  cfg_ready, busy, out_valid, out_ch, out_re, out_im, overrun
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_sel, cfg_data, en, step, clr_ovr,
    output cfg_ready, busy, out_valid, out_ch, out_re, out_im, overrun
  );

endinterface
`default_nettype wire

// File: rtl/qosc_cmul.sv
`default_nettype none
// ============================================================================
// qosc_cmul : shared complex multiplier, registered products + round/saturate
// Rev 1.0
// ============================================================================
module qosc_cmul
  import qosc_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld,
  input  logic signed [W-1:0]  a_re,
  input  logic signed [W-1:0]  a_im,
  input  logic signed [CW-1:0] c_re,
  input  logic signed [CW-1:0] c_im,
  output logic signed [W-1:0]  y_re,
  output logic signed [W-1:0]  y_im
);

  localparam int PW = W + CW;

  logic signed [PW-1:0] p_rc_q, p_rc_d;
  logic signed [PW-1:0] p_is_q, p_is_d;
  logic signed [PW-1:0] p_rs_q, p_rs_d;
  logic signed [PW-1:0] p_ic_q, p_ic_d;
  logic signed [PW:0]   sum_re;
  logic signed [PW:0]   sum_im;

  always_comb begin
    p_rc_d = p_rc_q;
    p_is_d = p_is_q;
    p_rs_d = p_rs_q;
    p_ic_d = p_ic_q;
    if (ld) begin
      p_rc_d = PW'(a_re) * PW'(c_re);
      p_is_d = PW'(a_im) * PW'(c_im);
      p_rs_d = PW'(a_re) * PW'(c_im);
      p_ic_d = PW'(a_im) * PW'(c_re);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rc_q <= '0;
      p_is_q <= '0;
      p_rs_q <= '0;
      p_ic_q <= '0;
    end else begin
      p_rc_q <= p_rc_d;
      p_is_q <= p_is_d;
      p_rs_q <= p_rs_d;
      p_ic_q <= p_ic_d;
    end
  end

  // One extra bit so c=s=-1.0 with full-scale accus cannot wrap before saturation.
  assign sum_re = (PW+1)'(p_rc_q) - (PW+1)'(p_is_q);
  assign sum_im = (PW+1)'(p_rs_q) + (PW+1)'(p_ic_q);

  assign y_re = W'(round_sat(64'(sum_re), W, CW));
  assign y_im = W'(round_sat(64'(sum_im), W, CW));

endmodule
`default_nettype wire

// File: rtl/qosc_multi.sv
`default_nettype none
// ============================================================================
// qosc_multi : CH-channel time-multiplexed quadrature oscillator bank
// Rev 1.0
// ============================================================================
module qosc_multi
  import qosc_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 16,
  parameter int CH = 4
) (
  input  logic        clk,
  input  logic        rst,
  qosc_multi_if.slave bus
);

  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic signed [CW-1:0] COEFF_ONE = {1'b0, {(CW-1){1'b1}}};
  localparam logic [CHW-1:0]       CH_LAST   = CHW'(CH - 1);

  qosc_state_t          state_q, state_d;
  logic [CHW-1:0]       ch_q, ch_d;
  logic                 chan_en_q, chan_en_d;

  logic signed [CW-1:0] coeff_re_q [CH];
  logic signed [CW-1:0] coeff_re_d [CH];
  logic signed [CW-1:0] coeff_im_q [CH];
  logic signed [CW-1:0] coeff_im_d [CH];
  logic signed [W-1:0]  accu_re_q  [CH];
  logic signed [W-1:0]  accu_re_d  [CH];
  logic signed [W-1:0]  accu_im_q  [CH];
  logic signed [W-1:0]  accu_im_d  [CH];

  logic                 out_valid_q, out_valid_d;
  logic [CHW-1:0]       out_ch_q, out_ch_d;
  logic signed [W-1:0]  out_re_q, out_re_d;
  logic signed [W-1:0]  out_im_q, out_im_d;
  logic                 overrun_q, overrun_d;

  logic                 busy;
  logic                 cfg_fire;
  logic                 cmul_ld;
  logic signed [W-1:0]  y_re;
  logic signed [W-1:0]  y_im;

  assign busy     = (state_q != ST_IDLE);
  assign cfg_fire = bus.cfg_valid && !busy && (int'(bus.cfg_ch) < CH);
  assign cmul_ld  = (state_q == ST_RUN_A);

  qosc_cmul #(
    .W  (W),
    .CW (CW)
  ) u_cmul (
    .clk  (clk),
    .rst  (rst),
    .ld   (cmul_ld),
    .a_re (accu_re_q[ch_q]),
    .a_im (accu_im_q[ch_q]),
    .c_re (coeff_re_q[ch_q]),
    .c_im (coeff_im_q[ch_q]),
    .y_re (y_re),
    .y_im (y_im)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    chan_en_d   = chan_en_q;
    coeff_re_d  = coeff_re_q;
    coeff_im_d  = coeff_im_q;
    accu_re_d   = accu_re_q;
    accu_im_d   = accu_im_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    overrun_d   = overrun_q;

    // Writes are only accepted in IDLE, so they never collide with writeback.
    if (cfg_fire) begin
      case (bus.cfg_sel)
        SEL_CRE: coeff_re_d[bus.cfg_ch] = bus.cfg_data[CW-1:0];
        SEL_CIM: coeff_im_d[bus.cfg_ch] = bus.cfg_data[CW-1:0];
        SEL_ARE: accu_re_d[bus.cfg_ch]  = bus.cfg_data[W-1:0];
        SEL_AIM: accu_im_d[bus.cfg_ch]  = bus.cfg_data[W-1:0];
        default: ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.step) begin
          state_d = ST_RUN_A;
          ch_d    = '0;
        end
      end
      ST_RUN_A: begin
        chan_en_d = bus.en[ch_q];
        state_d   = ST_RUN_B;
      end
      ST_RUN_B: begin
        if (chan_en_q) begin
          accu_re_d[ch_q] = y_re;
          accu_im_d[ch_q] = y_im;
          out_valid_d     = 1'b1;
          out_ch_d        = ch_q;
          out_re_d        = y_re;
          out_im_d        = y_im;
        end
        if (ch_q == CH_LAST) begin
          state_d = ST_IDLE;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = ST_RUN_A;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.step && busy) begin
      overrun_d = 1'b1;
    end else if (bus.clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      chan_en_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        coeff_re_q[i] <= COEFF_ONE;
        coeff_im_q[i] <= '0;
        accu_re_q[i]  <= '0;
        accu_im_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      chan_en_q   <= chan_en_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      overrun_q   <= overrun_d;
      coeff_re_q  <= coeff_re_d;
      coeff_im_q  <= coeff_im_d;
      accu_re_q   <= accu_re_d;
      accu_im_q   <= accu_im_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.cfg_ready = !busy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire
